// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Definitions shared by the unfolded radix-2 stage and its folded sequencer
// (stage_fold_ctrl).
//   - FFT frame geometry: 32 points, handled as 4 groups of 8 samples
//   - FSM state encoding for the folded sequencer
//   - the MAC-output to frame-slot mapping used by both stage variants
// No ports (package).
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_N      = 32;
  localparam int GROUPS     = 4;
  localparam int GROUP_SIZE = 8;
  localparam int MAC_LANES  = 4;   // butterflies per MAC issue (a0..a3 / b0..b3)
  localparam int GRP_W      = 2;   // bits needed to index GROUPS

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fold_state_e;

  // MAC output k lands at offset {0,4,1,5,2,6,3,7}[k] inside its group:
  // even outputs are the "a" half of each butterfly, odd outputs the "b" half.
  function automatic int slot_offset(input int k);
    if ((k % 2) == 1) begin
      slot_offset = MAC_LANES + (k / 2);
    end else begin
      slot_offset = k / 2;
    end
  endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// -----------------------------------------------------------------------------
// mac_tag_pipe
// Shift register that travels alongside the shared MAC so the controller knows
// which group (if any) is arriving on the MAC output. Depth equals the MAC
// latency; all stages clear on reset.
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   asynchronous, active-high reset
//   i_tag  in   tag entering with the MAC inputs ({valid, group})
//   o_tag  out  tag aligned with the MAC result, p_depth cycles later
// -----------------------------------------------------------------------------
module mac_tag_pipe #(
  parameter int p_depth = 1,
  parameter int p_width = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [p_width-1:0] i_tag,
  output logic [p_width-1:0] o_tag
);

  logic [p_width-1:0] r_stage [p_depth];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < p_depth; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < p_depth; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[p_depth-1];

endmodule

// File: rtl/stage_fold_ctrl.sv
// -----------------------------------------------------------------------------
// stage_fold_ctrl
// Sequencer for a folded radix-2 stage of the 32-point FFT. One shared MAC
// butterfly unit is time-multiplexed over the four 8-sample groups of a frame.
// The frame and twiddles are latched on start, one group is issued per cycle,
// and MAC results are scattered back into a 32-word output frame. o_done
// pulses for one cycle once the last group has been written.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for i_start; o_frame holds the previous result
// ST_ISSUE | group r_grp on o_macA/o_macB with o_macValid=1, four cycles
// ST_DRAIN | nothing issued; waiting for group 3 to leave the MAC
// ST_DONE  | one-cycle o_done pulse, then back to IDLE
//
// Ports:
//   CLK         in   clock, rising edge
//   RST         in   asynchronous, active-high reset
//   i_start     in   start request, only honoured in IDLE
//   i_frame     in   samples b0..b31, b_n at [n*p_inputBits +: p_inputBits]
//   i_widdle    in   twiddles w08..w38, one per slice
//   o_busy      out  frame in progress (ISSUE/DRAIN)
//   o_done      out  one-cycle completion pulse
//   o_frame     out  results c0..c31, same packing as i_frame
//   o_macA      out  MAC a0..a3 (zero when o_macValid=0)
//   o_macB      out  MAC b0..b3 (zero when o_macValid=0)
//   o_macW      out  latched twiddles to MAC c0..c3
//   o_macValid  out  o_macA/o_macB carry a live group
//   i_macOut    in   MAC out0..out7
// -----------------------------------------------------------------------------
module stage_fold_ctrl
  import fft_pkg::*;
#(
  parameter int p_inputBits  = 16,
  parameter int p_outputBits = 20,
  parameter int p_widdleBits = 4,
  parameter int p_macLatency = 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              i_start,
  input  logic [FFT_N*p_inputBits-1:0]      i_frame,
  input  logic [MAC_LANES*p_widdleBits-1:0] i_widdle,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [FFT_N*p_outputBits-1:0]     o_frame,
  output logic [MAC_LANES*p_inputBits-1:0]  o_macA,
  output logic [MAC_LANES*p_inputBits-1:0]  o_macB,
  output logic [MAC_LANES*p_widdleBits-1:0] o_macW,
  output logic                              o_macValid,
  input  logic [GROUP_SIZE*p_outputBits-1:0] i_macOut
);

  localparam int TAG_W = 1 + GRP_W;

  fold_state_e r_state;
  fold_state_e w_state_nxt;
  logic [GRP_W-1:0] r_grp;
  logic [GRP_W-1:0] w_grp_nxt;

  logic [FFT_N*p_inputBits-1:0]      r_frame;
  logic [MAC_LANES*p_widdleBits-1:0] r_widdle;
  logic [FFT_N*p_outputBits-1:0]     r_out;

  logic                              w_capture;
  logic                              w_issue;
  logic [GROUP_SIZE*p_inputBits-1:0] w_group;
  logic [TAG_W-1:0]                  w_tag_in;
  logic [TAG_W-1:0]                  w_tag_out;
  logic                              w_tag_valid;
  logic [GRP_W-1:0]                  w_tag_grp;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_grp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grp   <= w_grp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grp_nxt   = r_grp;
    w_capture   = 1'b0;
    w_issue     = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_capture   = 1'b1;
          w_grp_nxt   = '0;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_busy    = 1'b1;
        w_issue   = 1'b1;
        w_grp_nxt = r_grp + 1'b1;
        if (r_grp == GRP_W'(GROUPS - 1)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        // Groups leave the MAC in issue order, so group 3 is always last.
        if (w_tag_valid && (w_tag_grp == GRP_W'(GROUPS - 1))) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame / twiddle capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_frame  <= '0;
      r_widdle <= '0;
    end else if (w_capture) begin
      r_frame  <= i_frame;
      r_widdle <= i_widdle;
    end
  end

  // ---------------------------------------------------------------------------
  // MAC issue: group g supplies a = b[8g..8g+3], b = b[8g+4..8g+7]
  // ---------------------------------------------------------------------------
  assign w_group    = r_frame[r_grp*GROUP_SIZE*p_inputBits +: GROUP_SIZE*p_inputBits];
  assign o_macValid = w_issue;
  assign o_macA     = w_issue ? w_group[0 +: MAC_LANES*p_inputBits] : '0;
  assign o_macB     = w_issue ? w_group[MAC_LANES*p_inputBits +: MAC_LANES*p_inputBits] : '0;
  assign o_macW     = r_widdle;

  // ---------------------------------------------------------------------------
  // Tag pipe and result scatter
  // ---------------------------------------------------------------------------
  assign w_tag_in = {w_issue, r_grp};

  mac_tag_pipe #(
    .p_depth (p_macLatency),
    .p_width (TAG_W)
  ) u_tag_pipe (
    .CLK   (CLK),
    .RST   (RST),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign w_tag_valid = w_tag_out[TAG_W-1];
  assign w_tag_grp   = w_tag_out[GRP_W-1:0];

  // Only the slots of the arriving group are rewritten, so o_frame keeps the
  // previous result until the next frame's groups overwrite it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out <= '0;
    end else if (w_tag_valid) begin
      for (int k = 0; k < GROUP_SIZE; k++) begin
        r_out[(int'(w_tag_grp)*GROUP_SIZE + slot_offset(k))*p_outputBits +: p_outputBits]
          <= i_macOut[k*p_outputBits +: p_outputBits];
      end
    end
  end

  assign o_frame = r_out;

endmodule

// File: tb/tb_stage_fold_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stage_fold_ctrl
// Two controllers (MAC latency 1 and 3) each driven against a behavioural MAC
// stub of matching latency. Expected frames and done cycles are queued when a
// start is driven and compared when the controller pulses o_done.
// -----------------------------------------------------------------------------
module tb_stage_fold_ctrl;

  localparam int IW = 16;
  localparam int OW = 20;
  localparam int WW = 4;
  localparam int FW = 32 * OW;

  logic CLK;
  logic RST;
  logic st1, st3;
  logic [32*IW-1:0] frame;
  logic [4*WW-1:0]  wid;
  logic             mode;   // 0: echo stub, 1: constant 0xA0000+k stub

  logic             busy1, done1, mv1, busy3, done3, mv3;
  logic [FW-1:0]    of1, of3;
  logic [4*IW-1:0]  ma1, mb1, ma3, mb3;
  logic [4*WW-1:0]  mw1, mw3;
  logic [8*OW-1:0]  mo1, mo3;
  logic [8*OW-1:0]  s1, s3a, s3b, s3c;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [FW-1:0] fr;
    int            dc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  stage_fold_ctrl #(.p_inputBits(IW), .p_outputBits(OW), .p_widdleBits(WW), .p_macLatency(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .i_start(st1), .i_frame(frame), .i_widdle(wid),
    .o_busy(busy1), .o_done(done1), .o_frame(of1), .o_macA(ma1), .o_macB(mb1),
    .o_macW(mw1), .o_macValid(mv1), .i_macOut(mo1)
  );

  stage_fold_ctrl #(.p_inputBits(IW), .p_outputBits(OW), .p_widdleBits(WW), .p_macLatency(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .i_start(st3), .i_frame(frame), .i_widdle(wid),
    .o_busy(busy3), .o_done(done3), .o_frame(of3), .o_macA(ma3), .o_macB(mb3),
    .o_macW(mw3), .o_macValid(mv3), .i_macOut(mo3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [8*OW-1:0] stub_f(input logic [4*IW-1:0] a, input logic [4*IW-1:0] b,
                                             input logic m);
    logic [8*OW-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (m) begin
        r[(2*k)*OW +: OW]   = 20'hA0000 + 20'(2*k);
        r[(2*k+1)*OW +: OW] = 20'hA0000 + 20'(2*k+1);
      end else begin
        r[(2*k)*OW +: OW]   = {4'b0, a[k*IW +: IW]};
        r[(2*k+1)*OW +: OW] = {4'b0, b[k*IW +: IW]};
      end
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    s1  <= stub_f(ma1, mb1, mode);
    s3a <= stub_f(ma3, mb3, mode);
    s3b <= s3a;
    s3c <= s3b;
  end
  assign mo1 = s1;
  assign mo3 = s3c;

  function automatic logic [FW-1:0] exp_echo(input logic [32*IW-1:0] f);
    logic [FW-1:0] r;
    for (int n = 0; n < 32; n++) r[n*OW +: OW] = {4'b0, f[n*IW +: IW]};
    return r;
  endfunction

  // Slot j of a group holds out k where k = 2j (j<4) or 2(j-4)+1 (j>=4).
  function automatic logic [FW-1:0] exp_const();
    logic [FW-1:0] r;
    for (int g = 0; g < 4; g++)
      for (int j = 0; j < 8; j++)
        r[(8*g+j)*OW +: OW] = 20'hA0000 + 20'((j < 4) ? 2*j : 2*(j-4)+1);
    return r;
  endfunction

  function automatic logic [32*IW-1:0] rand_frame();
    logic [32*IW-1:0] r;
    for (int n = 0; n < 32; n++) r[n*IW +: IW] = 16'($urandom);
    return r;
  endfunction

  task automatic chk_val(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every o_done must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (done1) begin
      chk_val("busy1_at_done", FW'(busy1), '0);
      if (q1.size() == 0) begin
        chk_val("done1_unexpected", FW'(1), '0);
      end else begin
        e1 = q1.pop_front();
        chk_val("frame1", of1, e1.fr);
        chk_val("done1_cycle", FW'(cyc), FW'(e1.dc));
      end
    end
    if (done3) begin
      chk_val("busy3_at_done", FW'(busy3), '0);
      if (q3.size() == 0) begin
        chk_val("done3_unexpected", FW'(1), '0);
      end else begin
        e3 = q3.pop_front();
        chk_val("frame3", of3, e3.fr);
        chk_val("done3_cycle", FW'(cyc), FW'(e3.dc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk_val({tag, "_busy"},  FW'({busy1, busy3}), '0);
    chk_val({tag, "_done"},  FW'({done1, done3}), '0);
    chk_val({tag, "_valid"}, FW'({mv1, mv3}), '0);
    chk_val({tag, "_frame1"}, of1, '0);
    chk_val({tag, "_frame3"}, of3, '0);
    chk_val({tag, "_macA"},  FW'({ma1, ma3}), '0);
    chk_val({tag, "_macB"},  FW'({mb1, mb3}), '0);
    chk_val({tag, "_macW"},  FW'({mw1, mw3}), '0);
  endtask

  initial begin
    int c0;
    logic [32*IW-1:0] fa, fb, fc, fd;
    exp_t e;

    RST = 1'b0; st1 = 1'b0; st3 = 1'b0; frame = '0; wid = '0; mode = 1'b0;
    #1 RST = 1'b1;
    step(2);
    chk_zero_outputs("reset");
    RST = 1'b0;
    step(2);

    // Echo stub, b_n = n+1, both latencies in parallel.
    for (int n = 0; n < 32; n++) frame[n*IW +: IW] = 16'(n + 1);
    wid = 16'h4321;
    c0 = cyc;
    st1 = 1'b1; st3 = 1'b1;
    e.fr = exp_echo(frame); e.dc = c0 + 6; q1.push_back(e);
    e.dc = c0 + 8; q3.push_back(e);
    for (int k = 0; k <= 9; k++) begin
      chk_val("macValid1", FW'(mv1), FW'(k >= 1 && k <= 4));
      chk_val("macValid3", FW'(mv3), FW'(k >= 1 && k <= 4));
      chk_val("busy1", FW'(busy1), FW'(k >= 1 && k <= 5));
      chk_val("busy3", FW'(busy3), FW'(k >= 1 && k <= 7));
      if (k >= 1 && k <= 4) begin
        chk_val("macA1", FW'(ma1), FW'(frame[(8*(k-1))*IW +: 4*IW]));
        chk_val("macB1", FW'(mb1), FW'(frame[(8*(k-1)+4)*IW +: 4*IW]));
      end else begin
        chk_val("macAB1_idle", FW'({ma1, mb1}), '0);
      end
      if (k == 1) begin st1 = 1'b0; st3 = 1'b0; end
      if (k == 2) chk_val("macW1", FW'(mw1), FW'(16'h4321));
      step(1);
    end

    // Start held high: accepts at +0, +7, +14; frame changes between accepts.
    fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
    frame = fa;
    c0 = cyc;
    st1 = 1'b1;
    e.fr = exp_echo(fa); e.dc = c0 + 6;  q1.push_back(e);
    e.fr = exp_echo(fb); e.dc = c0 + 13; q1.push_back(e);
    e.fr = exp_echo(fc); e.dc = c0 + 20; q1.push_back(e);
    for (int k = 0; k <= 22; k++) begin
      if (k == 3)  frame = fb;
      if (k == 10) frame = fc;
      if (k == 15) st1 = 1'b0;
      if (k >= 6 && k <= 8) chk_val("busy1_rearm", FW'(busy1), FW'(k == 8));
      step(1);
    end

    // Inputs changed mid-frame must not disturb the latched frame/twiddles.
    fd = rand_frame();
    frame = fd; wid = 16'hA5C3;
    c0 = cyc;
    st1 = 1'b1;
    e.fr = exp_echo(fd); e.dc = c0 + 6; q1.push_back(e);
    for (int k = 0; k <= 8; k++) begin
      if (k == 1) st1 = 1'b0;
      if (k == 2) begin frame = '1; wid = '1; end
      if (k == 3) begin
        chk_val("macW_latched", FW'(mw1), FW'(16'hA5C3));
        chk_val("macA_latched", FW'(ma1), FW'(fd[16*IW +: 4*IW]));
      end
      step(1);
    end

    // Reset in cycle 3 aborts the frame without a done.
    frame = rand_frame();
    st1 = 1'b1; st3 = 1'b1;
    step(1);
    st1 = 1'b0; st3 = 1'b0;
    step(2);
    RST = 1'b1;
    #1;
    chk_zero_outputs("abort");
    step(1);
    RST = 1'b0;
    step(12);

    // Fresh frame after the abort.
    fa = rand_frame();
    frame = fa;
    c0 = cyc;
    st1 = 1'b1; st3 = 1'b1;
    e.fr = exp_echo(fa); e.dc = c0 + 6; q1.push_back(e);
    e.dc = c0 + 8; q3.push_back(e);
    step(1);
    st1 = 1'b0; st3 = 1'b0;
    step(10);

    // Constant stub: checks the out-to-slot scatter.
    mode = 1'b1;
    c0 = cyc;
    st1 = 1'b1; st3 = 1'b1;
    e.fr = exp_const(); e.dc = c0 + 6; q1.push_back(e);
    e.dc = c0 + 8; q3.push_back(e);
    step(1);
    st1 = 1'b0; st3 = 1'b0;
    step(10);

    chk_val("q1_drained", FW'(q1.size()), '0);
    chk_val("q3_drained", FW'(q3.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stage_fold_ctrl.md
# stage_fold_ctrl

Sequencer for a folded radix-2 stage of the 32-point FFT. It time-multiplexes one MAC butterfly unit (8 inputs, 4 twiddles, 8 outputs) across the four 8-sample groups of a 32-sample frame, where the unfolded stage uses four parallel MACs. It latches a frame and its twiddles on start, issues one group per cycle to the MAC, and scatters MAC results into a 32-word output frame. It pulses done when the frame is complete. It sits between stage registers and a single shared MAC instance.

## Interface
- p_inputBits, 16, width of one input sample
- p_outputBits, 20, width of one output sample / MAC result
- p_widdleBits, 4, width of one twiddle value
- p_macLatency, 1, MAC input-to-output latency in cycles, legal range 1..4

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- i_start  in  1  start request, sampled only in IDLE
- i_frame  in  32*p_inputBits  samples b0..b31, b_n at bits [n*p_inputBits +: p_inputBits]
- i_widdle  in  4*p_widdleBits  w08,w18,w28,w38, w_k at slice k
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle completion pulse
- o_frame  out  32*p_outputBits  result c0..c31, same packing as i_frame
- o_macA  out  4*p_inputBits  to MAC a0..a3
- o_macB  out  4*p_inputBits  to MAC b0..b3
- o_macW  out  4*p_widdleBits  to MAC c0..c3 (latched twiddles)
- o_macValid  out  1  current o_macA/B carry a live group
- i_macOut  in  8*p_outputBits  MAC out0..out7

## Operation
- Frame and twiddles are captured into internal registers when start is accepted. Later changes on i_frame / i_widdle do not affect the frame in flight.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on i_start go to ISSUE with group counter g=0.
  - ISSUE: drive group g, with o_macA = b[8g..8g+3] and o_macB = b[8g+4..8g+7]; o_macValid=1; g increments. After g=3 go to DRAIN.
  - DRAIN: o_macValid=0; wait until the last group is captured, then go to DONE.
  - DONE: o_done=1 for one cycle, then return to IDLE.
- A tag pipe of depth p_macLatency carries {valid, g} alongside the MAC. When the tag emerges valid, i_macOut is written into the output slots:
  - out0→c[8g], out1→c[8g+4]
  - out2→c[8g+1], out3→c[8g+5]
  - out4→c[8g+2], out5→c[8g+6]
  - out6→c[8g+3], out7→c[8g+7]
- No arithmetic in this block. Values pass through unmodified at full width.
- o_macA/o_macB are 0 whenever o_macValid=0.
- o_frame holds the completed result from done until the first capture of the next frame overwrites its slots.
- i_start while busy (ISSUE/DRAIN/DONE) is ignored. It is not queued.

## Timing
- Reset values:
  - o_busy=0, o_done=0, o_macValid=0
  - o_frame, o_macA, o_macB, o_macW all zero
  - FSM in IDLE, tag pipe cleared
- Cycle numbering, with start sampled at the edge ending cycle 0 (L = p_macLatency):
  - o_macValid=1 in cycles 1..4, group g issued in cycle 1+g
  - group g result sampled at the edge ending cycle 1+g+L, visible on o_frame from cycle 2+g+L
  - o_busy=1 in cycles 1..4+L
  - o_done=1 in cycle 5+L, with o_busy=0
  - a new start is accepted in cycle 6+L (IDLE)
- Issue-to-done latency: 5+L cycles. Throughput: one frame per 6+L cycles.
- RST asserted mid-frame: everything returns to reset values immediately, and no done is produced for the aborted frame.

## Structure
- Shared package fft_pkg holds:
  - FSM state enum
  - constant FFT_N=32, groups per frame = 4, group size = 8
  - the out-to-slot offset mapping {0,4,1,5,2,6,3,7} as a constant or function, so the unfolded stage and this controller share one definition
- One sub-module, mac_tag_pipe: a parameterised shift register of depth p_macLatency carrying {valid, group index}, reset to all-zero.

## Test plan
- Echo-stub MAC (L=1, out[2k]=a_k, out[2k+1]=b_k, zero-extended); i_frame b_n=n+1 → o_frame c_n=n+1 for all 32 slots; o_done exactly in cycle 6; o_macValid high exactly in cycles 1..4.
- Same stub with p_macLatency=3 → o_done in cycle 8; o_busy high in cycles 1..7; results unchanged.
- i_start held high continuously → frames accepted at cycles 0, 7, 14 (L=1); exactly one o_done per frame; starts pulsed mid-frame have no effect.
- Change i_frame and i_widdle to 0xFFFF / 0xF in cycle 2 of a frame → o_macW stays at the latched values and o_frame reflects the originally latched frame.
- Assert RST in cycle 3 → all outputs 0 in that same cycle; no o_done afterwards; a fresh start after release completes normally.
- Stub returning out_k = 0xA0000+k → o_frame slots c[8g..8g+7] equal {0xA0000, 0xA0002, 0xA0004, 0xA0006, 0xA0001, 0xA0003, 0xA0005, 0xA0007} for every g.
